// File: rtl/ijtag_scrambler.sv
// Secure-IJTAG enable scrambler. It drives one-hot segment enables in permuted order.
// An LFSR-chosen swap reshuffles the permutation table at every epoch boundary.
module ijtag_scrambler #(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned N_ENABLES = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [N_ENABLES-1:0] enables
);

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  localparam logic [15:0]          SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0]          POLY     = 16'hB400;
  localparam logic [SEL_WIDTH-1:0] CNT_LAST = SEL_WIDTH'(N_ENABLES - 1);

  logic [SEL_WIDTH-1:0] perm_q [N_ENABLES];
  logic [SEL_WIDTH-1:0] perm_d [N_ENABLES];
  logic [SEL_WIDTH-1:0] cnt_q;
  logic [SEL_WIDTH-1:0] cnt_d;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_d;
  logic [N_ENABLES-1:0] enables_q;
  logic [N_ENABLES-1:0] enables_d;

  logic                 epoch_end;
  logic [SEL_WIDTH-1:0] cur_sel;
  logic [SEL_WIDTH-1:0] swap_a;
  logic [SEL_WIDTH-1:0] swap_b;
  logic [SEL_WIDTH-1:0] val_a;
  logic [SEL_WIDTH-1:0] val_b;
  logic                 swap_en;

  always_comb begin
    epoch_end = (cnt_q == CNT_LAST);
    cnt_d     = epoch_end ? '0 : cnt_q + SEL_WIDTH'(1);
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY : 16'h0000);

    // The swap indices come from the LFSR value before this edge's step.
    swap_a  = lfsr_q[SEL_WIDTH-1:0];
    swap_b  = lfsr_q[2*SEL_WIDTH-1:SEL_WIDTH];
    swap_en = epoch_end && (swap_a != swap_b) &&
              (32'(swap_a) < N_ENABLES) && (32'(swap_b) < N_ENABLES);

    cur_sel = '0;
    val_a   = '0;
    val_b   = '0;
    for (int i = 0; i < N_ENABLES; i++) begin
      if (cnt_q == SEL_WIDTH'(i))  cur_sel = perm_q[i];
      if (swap_a == SEL_WIDTH'(i)) val_a   = perm_q[i];
      if (swap_b == SEL_WIDTH'(i)) val_b   = perm_q[i];
    end

    enables_d = '0;
    for (int i = 0; i < N_ENABLES; i++) begin
      enables_d[i] = (cur_sel == SEL_WIDTH'(i));
    end

    // The new table is first used at the start of the next epoch.
    for (int i = 0; i < N_ENABLES; i++) begin
      perm_d[i] = perm_q[i];
      if (swap_en && (swap_a == SEL_WIDTH'(i))) begin
        perm_d[i] = val_b;
      end else if (swap_en && (swap_b == SEL_WIDTH'(i))) begin
        perm_d[i] = val_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enables_q <= '0;
      cnt_q     <= '0;
      lfsr_q    <= SEED_EFF;
      for (int i = 0; i < N_ENABLES; i++) begin
        perm_q[i] <= SEL_WIDTH'(i);
      end
    end else begin
      enables_q <= enables_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      for (int i = 0; i < N_ENABLES; i++) begin
        perm_q[i] <= perm_d[i];
      end
    end
  end

  assign enables = enables_q;

endmodule

// File: tb/tb_ijtag_scrambler.sv
// Directed bench for ijtag_scrambler: a default (2,4,ACE1) instance and a (2,3,0) instance.
// Expected sequences were worked out by hand from the LFSR and the swap rule.
module tb_ijtag_scrambler;

  logic       clk;
  logic       reset;
  logic [3:0] en4;
  logic [2:0] en3;

  int n_cmp;
  int n_fail;

  // Default instance, epochs 1..3. The lfsr value used for each swap is 389C, then ED89.
  // Those values give perm [3,1,2,0] and then [3,2,1,0].
  logic [3:0] exp4 [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b1000, 4'b0010, 4'b0100, 4'b0001,
                            4'b1000, 4'b0100, 4'b0010, 4'b0001};
  // Three-enable instance, epochs 1..4. The swap lfsr values are 7138 (0<->2) and 0E27 (a=3, skipped).
  // The last one is C2C4 (0<->1).
  logic [2:0] exp3 [12] = '{3'b001, 3'b010, 3'b100,
                            3'b100, 3'b010, 3'b001,
                            3'b100, 3'b010, 3'b001,
                            3'b010, 3'b100, 3'b001};

  ijtag_scrambler u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .enables (en4)
  );

  ijtag_scrambler #(
    .SEL_WIDTH (2),
    .N_ENABLES (3),
    .SEED      (16'h0000)
  ) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .enables (en3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] seen4;
    logic [2:0] seen3;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;

    // Hold reset for three edges.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_en4", 8'(en4), 8'h00);
      check("reset_en3", 8'(en3), 8'h00);
    end
    reset = 1'b0;

    // First run after reset: directed sequences for both instances.
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("seq4_c%0d", k), 8'(en4), 8'(exp4[k]));
      check($sformatf("seq3_c%0d", k), 8'(en3), 8'(exp3[k]));
    end

    // Long run: one-hot every cycle, and every enable exactly once per epoch.
    seen4 = '0;
    seen3 = '0;
    for (int k = 0; k < 1008; k++) begin
      tick();
      check("onehot4", 8'($countones(en4)), 8'd1);
      check("onehot3", 8'($countones(en3)), 8'd1);
      check("repeat4", 8'(seen4 & en4), 8'h00);
      check("repeat3", 8'(seen3 & en3), 8'h00);
      seen4 = seen4 | en4;
      seen3 = seen3 | en3;
      if ((k % 4) == 3) begin
        check("epoch4_cover", 8'(seen4), 8'h0F);
        seen4 = '0;
      end
      if ((k % 3) == 2) begin
        check("epoch3_cover", 8'(seen3), 8'h07);
        seen3 = '0;
      end
    end

    // Reset asserted on the second cycle of an epoch.
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_en4", 8'(en4), 8'h00);
    check("mid_reset_en3", 8'(en3), 8'h00);
    tick();
    check("mid_hold_en4", 8'(en4), 8'h00);
    check("mid_hold_en3", 8'(en3), 8'h00);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rerun4_c%0d", k), 8'(en4), 8'(exp4[k]));
      check($sformatf("rerun3_c%0d", k), 8'(en3), 8'(exp3[k]));
    end

    // Reset on an epoch-end edge for both instances. Reset wins and no swap survives.
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("end_reset_en4", 8'(en4), 8'h00);
    check("end_reset_en3", 8'(en3), 8'h00);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("post_end4_c%0d", k), 8'(en4), 8'(exp4[k]));
      check($sformatf("post_end3_c%0d", k), 8'(en3), 8'(exp3[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
